// File: rtl/fir_sample_fifo.sv
// Sample FIFO between the FIR sample producer and the FIR datapath; stores DEPTH signed words.
// Latency: registered read, dout valid right after the edge that accepts ren; flags follow pointers combinationally.
// Backpressure: writes while full and reads while empty are dropped; the producer watches full, the consumer watches empty.
module fir_sample_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wen,
    input  logic [WIDTH-1:0]  din,
    output logic              full,
    input  logic              ren,
    output logic [WIDTH-1:0]  dout,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wptr;
    logic [ADDR_W:0]  rptr;
    logic             wr_ok;
    logic             rd_ok;

    // MSB of each pointer is a wrap bit, so equal low bits mean either empty or full.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign count = wptr - rptr;

    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                dout <= mem[rptr[ADDR_W-1:0]];
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Self-checking bench for fir_sample_fifo: stimulus pushes expected dout per read request, a monitor pops and compares.
module tb_fir_sample_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rstn;
    logic              wen;
    logic [WIDTH-1:0]  din;
    logic              full;
    logic              ren;
    logic [WIDTH-1:0]  dout;
    logic              empty;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q   [$];
    logic [WIDTH-1:0] last_rd;

    fir_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .wen   (wen),
        .din   (din),
        .full  (full),
        .ren   (ren),
        .dout  (dout),
        .empty (empty),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string name);
        chk({name, "_count"}, 32'(count), 32'(model_q.size()));
        chk({name, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({name, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    endtask

    // One clock with the given requests; the model decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r, input string name);
        bit wok;
        bit rok;
        wen = w;
        din = d;
        ren = r;
        wok = w && (model_q.size() < DEPTH);
        rok = r && (model_q.size() > 0);
        if (r) begin
            if (rok) last_rd = model_q.pop_front();
            exp_q.push_back(last_rd);
        end
        if (wok) model_q.push_back(d);
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        chk_flags(name);
    endtask

    // Monitor: every edge with ren high must present the next expected word.
    initial begin
        forever begin
            @(posedge clk);
            if (ren === 1'b1 && rstn === 1'b1) begin
                #2;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dout_noexp got %h expected none queued at %0t", dout, $time);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        errors++;
                        $display("FAIL dout got %h expected %h at %0t", dout, e, $time);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string name);
        chk({name, "_dout"},  32'(dout),  32'h0);
        chk({name, "_empty"}, 32'(empty), 32'h1);
        chk({name, "_full"},  32'(full),  32'h0);
        chk({name, "_count"}, 32'(count), 32'h0);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
        last_rd = '0;
        rstn = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check_reset_state("reset");

        // Mid-burst asynchronous reset
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b0, "preburst");
        #2;
        rstn = 1'b0;
        #1;
        check_reset_state("midreset");
        model_q.delete();
        last_rd = '0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check_reset_state("postreset");

        // Fill with distinct signed values, then an overflow write
        for (int i = 0; i < DEPTH; i++) begin
            v = 16'h8000 ^ 16'(i * 257);
            cycle(1'b1, v, 1'b0, "fill");
        end
        cycle(1'b1, 16'h7FFF, 1'b0, "overflow");
        chk("overflow_count", 32'(count), 32'd64);

        // Drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "drain");
        chk("drain_last", 32'(dout), 32'(16'h8000 ^ 16'(63 * 257)));

        // Underflow: dout holds the 64th word
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "underflow");
        cycle(1'b1, 16'hA5C3, 1'b0, "uf_wr");
        cycle(1'b0, '0, 1'b1, "uf_rd");

        // Concurrent read/write with 16 preloaded words
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'hF000 + i), 1'b0, "preload");
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h0B00 + i), 1'b1, "concurrent");
        chk("concurrent_count", 32'(count), 32'd16);
        for (int i = 0; i < 24; i++) cycle(1'b0, '0, 1'b1, "conc_drain");

        // Wrap cycles; third fill ends with simultaneous wen/ren while full
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 16'((k + 1) * 16'h1111) ^ 16'(i * 1031);
                cycle(1'b1, v, 1'b0, "wrap_fill");
            end
            if (k == 2) begin
                cycle(1'b1, 16'hDEAD, 1'b1, "full_rw");
                chk("full_rw_count", 32'(count), 32'd63);
                for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, "wrap_drain");
            end else begin
                for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "wrap_drain");
            end
        end
        cycle(1'b0, '0, 1'b1, "final_underflow");

        @(posedge clk);
        #4;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sample_fifo.md
Name: fir_sample_fifo

Overview:
- Single-clock, first-word-fall-through-free (registered-read) FIFO buffering signed FIR samples between a sample producer and the FIR datapath consumer.
- Stores up to DEPTH words of WIDTH-bit signed data and exposes full/empty status plus an occupancy count.
- Data is returned in strict write order; writes while full and reads while empty are ignored.

Parameters:
- WIDTH, 16, data word width in bits (two's-complement signed)
- DEPTH, 64, number of storage entries (power of two)
- ADDR_W, 6, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rstn  input  1  asynchronous, active-low reset
- wen  input  1  write request, sampled at rising clk
- din  input  WIDTH  signed write data, sampled with wen
- full  output  1  high when DEPTH entries are stored
- ren  input  1  read request, sampled at rising clk
- dout  output  WIDTH  signed registered read data
- empty  output  1  high when no entries are stored
- count  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: asserting rstn low immediately clears the write pointer, the read pointer and count to 0, and sets dout=0, empty=1, full=0. Reset applies at any time, including mid-operation. Memory contents need not be cleared.
- Pointers: the write and read pointers are each ADDR_W+1 bits wide. The low ADDR_W bits address the memory; the MSB is a wrap bit.
- Flags are derived combinationally from the pointers:
  - empty = (wptr == rptr)
  - full = (low bits equal AND MSBs differ)
  - count = wptr - rptr, taken modulo 2^(ADDR_W+1)
- Write: when wen=1 and full=0 at the rising edge, mem[wptr] <= din and wptr increments. When wen=1 and full=1, nothing changes (overflow dropped).
- Read: when ren=1 and empty=0 at the rising edge, dout <= mem[rptr] and rptr increments. The data is therefore valid after that same edge: a one-cycle registered read latency. When ren=1 and empty=1, dout holds its previous value and rptr does not change.
- dout holds its value on every cycle without an accepted read.
- Flag timing: empty deasserts and count increments in the cycle after the first accepted write edge, with no extra synchronizer latency. full asserts immediately after the edge that accepts the DEPTH-th unread word.
- Simultaneous wen and ren:
  - Each operation is gated by the pre-edge flags.
  - If not empty and not full, both occur, count is unchanged, and the newly read word is the oldest entry.
  - If empty, only the write occurs; the incoming word is not bypassed to dout.
  - If full, only the read occurs; the write is dropped.
- Wrap-around: pointers wrap naturally modulo 2*DEPTH. Ordering is preserved across any number of wraps.
- Arithmetic: data is passed through bit-exact; no sign extension or saturation.

Test Plan:
- Reset: hold rstn=0 for 5 cycles, then release → dout=0, empty=1, full=0, count=0. Asserting rstn low mid-burst immediately returns to the same values.
- Fill: 64 writes of distinct random signed values → count increments 1..64, empty drops after the first write, full=1 after the 64th. A 65th write with din=16'h7FFF is ignored and count stays 64.
- Drain: 64 single-cycle ren pulses → each dout, checked one edge after ren, equals the written values in order. full drops after the first read, empty=1 and count=0 after the 64th.
- Underflow: ren=1 for 3 cycles while empty → dout holds its last value (the 64th word), pointers and count are unchanged, and a subsequent write/read pair still returns the correct data.
- Concurrent: preload 16 words, then assert wen and ren together for 8 cycles with new data → count stays 16, dout returns words 0..7, and a final drain returns words 8..15 then the 8 new words.
- Wrap and edge cases: three fill/drain cycles of 64 each, with the third fill overlapping a full-state simultaneous wen/ren → order is preserved across pointer wrap, and the write issued while full is dropped.
